// File: rtl/fetch_stage.sv
// fetch_stage: program counter plus IF/ID register, feeding decode from a combinational instruction memory.
// Latency: the word at imem_a appears on id_* one cycle later; a redirect costs one bubble cycle.
// Backpressure: id_valid && !id_ready freezes pc and id_*; a redirect flushes the register regardless of id_ready.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset (wins over all other inputs)
//   imem_a / imem_rd    word-aligned fetch address out, instruction word back in the same cycle
//   redirect, redirect_pc  single-cycle PC load from execute; target bits [1:0] are dropped
//   id_valid/id_ready   IF/ID handshake; id_instr, id_pc, id_pc8 (= id_pc + 8, wrapping) are the payload
// Optional feature: define FETCH_PERF_EN to add the perf_fetch, perf_stall and perf_flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    // The IF/ID register is the only state machine: it is either empty or holds one instruction.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ifid_state_t;

    ifid_state_t state;
    ifid_state_t state_nxt;
    logic [31:0] pc;
    logic        advance;

    assign imem_a   = pc;
    assign id_valid = (state == ST_FULL);
    // The register can take a new word when it is empty or its current word leaves this cycle.
    assign advance  = !id_valid || id_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            // An empty register always fetches unless the cycle is spent loading a new pc.
            ST_EMPTY: if (!redirect) state_nxt = ST_FULL;
            // A full register stays full on both refill and stall; only a redirect empties it.
            ST_FULL:  if (redirect)  state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            pc       <= RESET_PC_ALIGNED;
            id_instr <= '0;
            id_pc    <= '0;
            id_pc8   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                // imem_rd belongs to the wrong path this cycle, so it is dropped.
                pc <= redirect_pc & ~32'h3;
            end else if (advance) begin
                id_instr <= imem_rd;
                id_pc    <= pc;
                id_pc8   <= pc + 32'd8;
                pc       <= pc + PC_INC;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (id_valid && id_ready)  perf_fetch <= perf_fetch + 32'd1;
            if (id_valid && !id_ready) perf_stall <= perf_stall + 32'd1;
            // Only a redirect that discards a real instruction counts as a flush.
            if (redirect && id_valid)  perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule
